// File: rtl/seq_pattern_checker.sv
// Pattern checker for the 4-symbol cyclic generator stream: hunts for phase, locks after
// LOCK_CNT good symbols, flywheels while locked and counts mismatches in a saturating counter.
module seq_pattern_checker #(
  parameter logic [3:0]  SYM0        = 4'b0011,
  parameter logic [3:0]  SYM1        = 4'b0110,
  parameter logic [3:0]  SYM2        = 4'b0001,
  parameter logic [3:0]  SYM3        = 4'b0100,
  parameter int unsigned LOCK_CNT    = 4,
  parameter int unsigned UNLOCK_ERRS = 2,
  parameter int unsigned ERR_CNT_W   = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  input  logic [3:0]           in_sym,
  input  logic                 clr_count,
  output logic                 locked,
  output logic                 sym_err,
  output logic [ERR_CNT_W-1:0] err_count,
  output logic [3:0]           exp_sym
);

  typedef enum logic [1:0] {HUNT = 2'd0, SYNC = 2'd1, LOCKED = 2'd2} state_t;

  localparam logic [3:0] LOCK_N   = 4'(LOCK_CNT);
  localparam logic [3:0] UNLOCK_N = 4'(UNLOCK_ERRS);

  state_t               state_q, state_d;
  logic [1:0]           phase_q, phase_d;
  logic [3:0]           run_q, run_d;
  logic [3:0]           bad_run_q, bad_run_d;
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic                 sym_err_q, sym_err_d;
  logic                 locked_q, locked_d;
  logic [3:0]           exp_sym_q, exp_sym_d;

  logic                 match;
  logic                 seed_hit;
  logic [1:0]           seed_k;
  logic                 err_event;
  logic [3:0]           run_inc;
  logic [3:0]           bad_inc;

  function automatic logic [3:0] sym_at(input logic [1:0] p);
    case (p)
      2'd0:    sym_at = SYM0;
      2'd1:    sym_at = SYM1;
      2'd2:    sym_at = SYM2;
      default: sym_at = SYM3;
    endcase
  endfunction

  assign match     = (in_sym == sym_at(phase_q));
  assign run_inc   = run_q + 4'd1;
  assign bad_inc   = bad_run_q + 4'd1;
  assign err_event = in_valid && (state_q == LOCKED) && !match;

  // Lowest-index symbol wins when pattern symbols alias each other.
  always_comb begin
    seed_hit = 1'b1;
    seed_k   = 2'd0;
    if (in_sym == SYM0)      seed_k = 2'd0;
    else if (in_sym == SYM1) seed_k = 2'd1;
    else if (in_sym == SYM2) seed_k = 2'd2;
    else if (in_sym == SYM3) seed_k = 2'd3;
    else                     seed_hit = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= HUNT;
      phase_q   <= 2'd0;
      run_q     <= 4'd0;
      bad_run_q <= 4'd0;
      err_cnt_q <= '0;
      sym_err_q <= 1'b0;
      locked_q  <= 1'b0;
      exp_sym_q <= 4'd0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      run_q     <= run_d;
      bad_run_q <= bad_run_d;
      err_cnt_q <= err_cnt_d;
      sym_err_q <= sym_err_d;
      locked_q  <= locked_d;
      exp_sym_q <= exp_sym_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    run_d     = run_q;
    bad_run_d = bad_run_q;
    if (in_valid) begin
      case (state_q)
        HUNT: begin
          if (seed_hit) begin
            phase_d   = seed_k + 2'd1;
            run_d     = 4'd1;
            bad_run_d = 4'd0;
            state_d   = (LOCK_N == 4'd1) ? LOCKED : SYNC;
          end
        end
        SYNC: begin
          if (match) begin
            phase_d = phase_q + 2'd1;
            run_d   = run_inc;
            if (run_inc == LOCK_N) begin
              state_d   = LOCKED;
              bad_run_d = 4'd0;
            end
          end else begin
            state_d = HUNT;
            run_d   = 4'd0;
          end
        end
        LOCKED: begin
          // Phase advances on errors too so a single corrupted symbol does not slip alignment.
          phase_d = phase_q + 2'd1;
          if (match) begin
            bad_run_d = 4'd0;
          end else if (bad_inc == UNLOCK_N) begin
            state_d   = HUNT;
            run_d     = 4'd0;
            bad_run_d = 4'd0;
          end else begin
            bad_run_d = bad_inc;
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  always_comb begin
    locked_d  = (state_d == LOCKED);
    exp_sym_d = (state_d == HUNT) ? 4'd0 : sym_at(phase_d);
    sym_err_d = err_event;
    err_cnt_d = err_cnt_q;
    if (clr_count)
      err_cnt_d = err_event ? ERR_CNT_W'(1) : '0;
    else if (err_event && !(&err_cnt_q))
      err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
  end

  assign locked    = locked_q;
  assign sym_err   = sym_err_q;
  assign err_count = err_cnt_q;
  assign exp_sym   = exp_sym_q;

endmodule
